imem_loader: RTL and testbench

Program loader that writes the instruction memory. It takes a byte stream over a valid/ready handshake, packs the bytes little-endian into 32-bit instruction words, and issues one-cycle write strobes at consecutive word-aligned byte addresses starting at 0. The write addresses use the same convention as the fetch side, which reads word index = address >> 2. It sits between the host/UART byte source and the instruction memory's write port, and it holds the core's fetch in reset until `done`.

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and byte-lane constants for the
// instruction-memory loader and its word packer.
package imem_loader_pkg;

  // Loader session states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One instruction word is four byte lanes; the lane index needs two bits.
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

endpackage : imem_loader_pkg

// File: rtl/imem_word_packer.sv
// imem_word_packer: collects stream bytes little-endian into one 32-bit word.
// Byte k of a word lands in bits [8k+7:8k]; lanes not yet written stay 0,
// so a word closed early by the last byte is zero-padded.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,      // drop the word in progress, restart at lane 0
  input  logic              i_byte_en,    // a byte is accepted this cycle
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_full   // next accepted byte completes the word
);

  logic [LANE_W-1:0] r_lane;
  logic [WORD_W-1:0] r_word;

  // Lane counter and word register; clear has priority over a new byte.
  // NOTE: the word register is a plain 32-bit flop, not a memory, so it is
  // reset like any other state; zero lanes are what produce the padding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_lane <= '0;
      r_word <= '0;
    end else if (i_byte_en) begin
      r_lane <= r_lane + 1'b1;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (r_lane == LANE_W'(k)) begin
          r_word[k*BYTE_W +: BYTE_W] <= i_byte;
        end
      end
    end
  end

  assign o_word      = r_word;
  assign o_word_full = (r_lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule : imem_word_packer

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Accepts bytes over valid/ready, packs them into 32-bit words and writes
// them at byte addresses 0, 4, 8, ... (fetch reads word index = addr >> 2).
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a 32-bit running sum of
// all written words on output `checksum`.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MEM_SIZE       = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  input  logic                      byte_last,
  output logic                      byte_ready,
  output logic                      wr_en,
  output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [$clog2(MEM_SIZE):0] word_count,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [31:0]               checksum,
`endif
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int CW = $clog2(MEM_SIZE) + 1;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_word_count;
  logic              r_overflow;
  logic              r_last_word;   // word being assembled holds the final byte

  logic              w_accept;
  logic              w_mem_full;
  logic              w_word_full;
  logic              w_pack_en;
  logic              w_pack_clear;
  logic              w_write;
  logic              w_set_overflow;
  logic [WORD_W-1:0] w_word;

  assign w_accept   = byte_valid && (r_state == LOAD);
  assign w_mem_full = (r_word_count == CW'(MEM_SIZE));

  // Byte packing: one lane per accepted byte, cleared on start and after each write.
  imem_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_pack_clear),
    .i_byte_en   (w_pack_en),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-cycle controls; start overrides everything.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_next         = r_state;
    w_pack_en      = 1'b0;
    w_pack_clear   = 1'b0;
    w_write        = 1'b0;
    w_set_overflow = 1'b0;
    if (start) begin
      // A pending word is discarded and a WRITE in flight is suppressed.
      w_next       = LOAD;
      w_pack_clear = 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_next = IDLE;
        end
        LOAD: begin
          if (w_accept) begin
            if (w_mem_full) begin
              w_next         = DONE;
              w_set_overflow = 1'b1;
            end else begin
              w_pack_en = 1'b1;
              if (w_word_full || byte_last) begin
                w_next = WRITE;
              end
            end
          end
        end
        WRITE: begin
          w_write      = 1'b1;
          w_pack_clear = 1'b1;
          w_next       = r_last_word ? DONE : LOAD;
        end
        DONE: begin
          w_next = DONE;
        end
        default: begin
          w_next = IDLE;
        end
      endcase
    end
  end

  // Word counter, sticky overflow and last-word marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_last_word  <= 1'b0;
    end else if (start) begin
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_last_word  <= 1'b0;
    end else begin
      if (w_write) begin
        r_word_count <= r_word_count + 1'b1;
      end
      if (w_set_overflow) begin
        r_overflow <= 1'b1;
      end
      if (w_pack_en) begin
        r_last_word <= byte_last;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Running modulo-2^32 sum of every word actually written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_checksum <= '0;
    end else if (start) begin
      r_checksum <= '0;
    end else if (w_write) begin
      r_checksum <= r_checksum + w_word;
    end
  end

  assign checksum = r_checksum;
`endif

  assign byte_ready = (r_state == LOAD);
  assign wr_en      = w_write;
  assign wr_addr    = MEM_ADDR_WIDTH'(r_word_count) << 2;
  assign wr_data    = w_word;
  assign word_count = r_word_count;
  assign busy       = (r_state == LOAD) || (r_state == WRITE);
  assign done       = (r_state == DONE);
  assign overflow   = r_overflow;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader (MEM_SIZE=4).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  word_count;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_vec  = 0;
  int n_err  = 0;
  int n_viol = 0;
  int nw     = 0;
  logic [31:0] wa [16];
  logic [31:0] wd [16];

  imem_loader #(
    .DATA_WIDTH     (32),
    .MEM_ADDR_WIDTH (32),
    .MEM_SIZE       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .word_count (word_count),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Write log and ready/write exclusivity, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      if (nw < 16) begin
        wa[nw] = wr_addr;
        wd[nw] = wr_data;
      end
      nw = nw + 1;
    end
    if (busy && !start && (byte_ready === wr_en)) n_viol = n_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a byte until it transfers; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    while (byte_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_ready", {31'd0, byte_ready}, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  logic [31:0] exp_ovf [4] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};
  int base;

  initial begin
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
    #1;
    chk("rst_ready",    {31'd0, byte_ready}, 32'd0);
    chk("rst_wr_en",    {31'd0, wr_en},      32'd0);
    chk("rst_busy",     {31'd0, busy},       32'd0);
    chk("rst_done",     {31'd0, done},       32'd0);
    chk("rst_overflow", {31'd0, overflow},   32'd0);
    chk("rst_addr",     wr_addr,             32'd0);
    chk("rst_data",     wr_data,             32'd0);
    chk("rst_count",    {29'd0, word_count}, 32'd0);
    #16 rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, byte_ready}, 32'd0);

    // Two full words, last on the 8th byte, valid kept high throughout.
    pulse_start();
    chk("start_ready", {31'd0, byte_ready}, 32'd1);
    chk("start_busy",  {31'd0, busy},       32'd1);
    base = nw;
    send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    chk("w0_en",    {31'd0, wr_en},      32'd1);
    chk("w0_ready", {31'd0, byte_ready}, 32'd0);
    chk("w0_addr",  wr_addr,             32'h0);
    chk("w0_data",  wr_data,             32'h00000013);
    send(8'h93, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0); send(8'h00, 1'b1);
    chk("w1_en",   {31'd0, wr_en}, 32'd1);
    chk("w1_addr", wr_addr,        32'h4);
    chk("w1_data", wr_data,        32'h00100093);
    @(posedge clk); #1;
    chk("t1_done",  {31'd0, done},       32'd1);
    chk("t1_busy",  {31'd0, busy},       32'd0);
    chk("t1_count", {29'd0, word_count}, 32'd2);
    chk("t1_nw",    nw - base,           32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t1_checksum", checksum, 32'h001000A6);
`endif
    // Bytes in DONE are refused.
    byte_valid = 1'b1; byte_data = 8'h55;
    chk("done_ready", {31'd0, byte_ready}, 32'd0);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    chk("done_hold",  {31'd0, done},       32'd1);
    chk("done_count", {29'd0, word_count}, 32'd2);

    // Last byte in lane 1: zero-padded single write.
    pulse_start();
    chk("t2_done_clr",  {31'd0, done},       32'd0);
    chk("t2_count_clr", {29'd0, word_count}, 32'd0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    chk("t2_en",   {31'd0, wr_en}, 32'd1);
    chk("t2_addr", wr_addr,        32'h0);
    chk("t2_data", wr_data,        32'h0000BBAA);
    @(posedge clk); #1;
    chk("t2_done",  {31'd0, done},       32'd1);
    chk("t2_count", {29'd0, word_count}, 32'd1);

    // Fill all four words, then one more byte overflows.
    pulse_start();
    base = nw;
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
    send(8'h20, 1'b0);
    chk("ovf_flag",  {31'd0, overflow},   32'd1);
    chk("ovf_done",  {31'd0, done},       32'd1);
    chk("ovf_wr_en", {31'd0, wr_en},      32'd0);
    chk("ovf_count", {29'd0, word_count}, 32'd4);
    chk("ovf_nw",    nw - base,           32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_addr%0d", k), wa[base + k], 32'(4 * k));
      chk($sformatf("ovf_data%0d", k), wd[base + k], exp_ovf[k]);
    end
    @(posedge clk); #1;
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Restart after two bytes: partial word discarded.
    pulse_start();
    chk("t4_ovf_clr", {31'd0, overflow},   32'd0);
    chk("t4_done",    {31'd0, done},       32'd0);
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    pulse_start();
    chk("t4_count", {29'd0, word_count}, 32'd0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("t4_en",   {31'd0, wr_en}, 32'd1);
    chk("t4_addr", wr_addr,        32'h0);
    chk("t4_data", wr_data,        32'h04030201);

    // Start during WRITE suppresses that write.
    pulse_start();
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0); send(8'hA4, 1'b0);
    base = nw;
    start = 1'b1;
    #1;
    chk("sw_wr_en", {31'd0, wr_en}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("sw_count", {29'd0, word_count}, 32'd0);
    chk("sw_ready", {31'd0, byte_ready}, 32'd1);
    chk("sw_nw",    nw - base,           32'd0);

    // Reset between the 4th-byte edge and the WRITE cycle.
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0);
    byte_valid = 1'b1; byte_data = 8'hC4;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    base = nw;
    rst = 1'b1;
    #1;
    chk("ar_wr_en", {31'd0, wr_en},      32'd0);
    chk("ar_ready", {31'd0, byte_ready}, 32'd0);
    chk("ar_busy",  {31'd0, busy},       32'd0);
    chk("ar_done",  {31'd0, done},       32'd0);
    chk("ar_ovf",   {31'd0, overflow},   32'd0);
    chk("ar_addr",  wr_addr,             32'd0);
    chk("ar_data",  wr_data,             32'd0);
    chk("ar_count", {29'd0, word_count}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("ar_nw", nw - base, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ar_idle_ready", {31'd0, byte_ready}, 32'd0);

    chk("ready_vs_write", n_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_imem_loader
